// File: rtl/rot_sched.sv
// rot_sched: round-robin scheduler time-sharing one log-staged barrel rotator among N_REQ requesters.
module rot_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int AMT_W = 3,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ*AMT_W-1:0] req_amt,
    input  logic [N_REQ-1:0]       req_dir,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [ID_W-1:0]        out_id
);
    localparam int KW = AMT_W > 1 ? $clog2(AMT_W) : 1;
    localparam logic [1:0] IDLE = 2'd0, STAGE = 2'd1, DONE = 2'd2;
    logic [1:0]         state;
    logic [KW-1:0]      k;
    logic [ID_W-1:0]    rr_ptr, id, g;
    logic [WIDTH-1:0]   work, stepped;
    logic [AMT_W-1:0]   amt;
    logic               dir, any;
    logic [2*N_REQ-1:0] vv;
    // Valids rotated so bit 0 is rr_ptr; scanning down lets the lowest offset win.
    always_comb begin
        vv = {req_valid, req_valid} >> rr_ptr;
        any = 1'b0;
        g = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vv[i]) begin
                any = 1'b1;
                g = ID_W'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end
    always_comb begin
        stepped = !amt[k] ? work
                : dir ? WIDTH'(({work, work} << (1 << k)) >> WIDTH)
                : WIDTH'({work, work} >> (1 << k));
    end
    assign req_ready = (rst_n && state == IDLE && any) ? N_REQ'(1) << g : '0;
    assign out_valid = state == DONE;
    assign out_data  = work;
    assign out_id    = id;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            k      <= '0;
            rr_ptr <= '0;
            work   <= '0;
            amt    <= '0;
            dir    <= 1'b0;
            id     <= '0;
        end else if (state == IDLE) begin
            if (any) begin
                state  <= STAGE;
                k      <= '0;
                rr_ptr <= ID_W'((int'(g) + 1) % N_REQ);
                work   <= WIDTH'(req_data >> (int'(g) * WIDTH));
                amt    <= AMT_W'(req_amt >> (int'(g) * AMT_W));
                dir    <= req_dir[g];
                id     <= g;
            end
        end else if (state == STAGE) begin
            work  <= stepped;
            k     <= k + 1'b1;
            state <= (k == KW'(AMT_W - 1)) ? DONE : STAGE;
        end else if (out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_rot_sched.sv
// tb_rot_sched: directed scenarios for rot_sched with hand-computed rotate results.
module tb_rot_sched;
    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [11:0] req_amt;
    logic [3:0]  req_dir;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic [7:0]  d [4];
    logic [2:0]  a [4];
    int n_chk, n_pass;

    assign req_data = {d[3], d[2], d[1], d[0]};
    assign req_amt  = {a[3], a[2], a[1], a[0]};

    rot_sched dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_amt(req_amt), .req_dir(req_dir),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 4'hF;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b exp=0", out_valid); else n_pass++;
        n_chk++; if (out_data !== 8'h00) $display("FAIL rst_out_data got=%h exp=00", out_data); else n_pass++;
        n_chk++; if (out_id !== 2'd0) $display("FAIL rst_out_id got=%0d exp=0", out_id); else n_pass++;
        n_chk++; if (req_ready !== 4'b0000) $display("FAIL rst_req_ready got=%b exp=0000", req_ready); else n_pass++;
        req_valid = 4'h0;
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) $display("FAIL idle_out_valid got=%0b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_single_op(input logic [1:0] id, input logic [7:0] data, input logic [2:0] amt,
                                  input logic dir, input logic [7:0] exp, input string name);
        d[id] = data;
        a[id] = amt;
        req_dir[id] = dir;
        req_valid = 4'(1) << id;
        out_ready = 1'b1;
        #1;
        n_chk++; if (req_ready !== 4'(1) << id) $display("FAIL %s_grant got=%b exp=%b", name, req_ready, 4'(1) << id); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_chk++; if (req_ready !== 4'b0000) $display("FAIL %s_ready_one_cycle got=%b exp=0000", name, req_ready); else n_pass++;
        req_valid = 4'h0;
        d[id] = ~data;
        a[id] = ~amt;
        req_dir[id] = ~dir;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) @(negedge clk);
            n_chk++; if (out_valid !== 1'b0) $display("FAIL %s_early_valid cycle=%0d got=%0b exp=0", name, c, out_valid); else n_pass++;
        end
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1) $display("FAIL %s_valid got=%0b exp=1", name, out_valid); else n_pass++;
        n_chk++; if (out_data !== exp) $display("FAIL %s_data got=%h exp=%h", name, out_data, exp); else n_pass++;
        n_chk++; if (out_id !== id) $display("FAIL %s_id got=%0d exp=%0d", name, out_id, id); else n_pass++;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) $display("FAIL %s_released got=%0b exp=0", name, out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] ex [4];
        logic [3:0] exp_rdy;
        logic [1:0] k;
        ex[0] = 8'h0F; ex[1] = 8'h1E; ex[2] = 8'hC3; ex[3] = 8'h78;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d[i] = 8'h0F;
            a[i] = 3'(i);
        end
        req_dir = 4'b1010;
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            k = 2'(c / 5);
            exp_rdy = (c % 5 == 0) ? 4'(1) << k : 4'b0000;
            n_chk++; if (req_ready !== exp_rdy) $display("FAIL b2b_ready cycle=%0d got=%b exp=%b", c, req_ready, exp_rdy); else n_pass++;
            n_chk++; if (out_valid !== (c % 5 == 4)) $display("FAIL b2b_valid cycle=%0d got=%0b exp=%0b", c, out_valid, c % 5 == 4); else n_pass++;
            if (c % 5 == 4) begin
                n_chk++; if (out_id !== k) $display("FAIL b2b_id cycle=%0d got=%0d exp=%0d", c, out_id, k); else n_pass++;
                n_chk++; if (out_data !== ex[k]) $display("FAIL b2b_data cycle=%0d got=%h exp=%h", c, out_data, ex[k]); else n_pass++;
            end
        end
        req_valid = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        d[3] = 8'hA5; a[3] = 3'd2; req_dir[3] = 1'b1;
        req_valid = 4'b1000;
        out_ready = 1'b0;
        #1;
        n_chk++; if (req_ready !== 4'b1000) $display("FAIL bp_grant got=%b exp=1000", req_ready); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0001;
        d[0] = 8'h77; a[0] = 3'd0; req_dir[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_chk++; if (out_valid !== 1'b1) $display("FAIL bp_valid cycle=%0d got=%0b exp=1", c, out_valid); else n_pass++;
            n_chk++; if (out_data !== 8'h96) $display("FAIL bp_data cycle=%0d got=%h exp=96", c, out_data); else n_pass++;
            n_chk++; if (out_id !== 2'd3) $display("FAIL bp_id cycle=%0d got=%0d exp=3", c, out_id); else n_pass++;
            n_chk++; if (req_ready !== 4'b0000) $display("FAIL bp_no_grant cycle=%0d got=%b exp=0000", c, req_ready); else n_pass++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_handshake got=%0b exp=0", out_valid); else n_pass++;
        n_chk++; if (req_ready !== 4'b0001) $display("FAIL bp_next_grant got=%b exp=0001", req_ready); else n_pass++;
        req_valid = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_reset_midop;
        d[2] = 8'hFF; a[2] = 3'd0; req_dir[2] = 1'b0;
        req_valid = 4'b0100;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'h0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL arst_valid got=%0b exp=0", out_valid); else n_pass++;
        n_chk++; if (out_data !== 8'h00) $display("FAIL arst_data got=%h exp=00", out_data); else n_pass++;
        n_chk++; if (out_id !== 2'd0) $display("FAIL arst_id got=%0d exp=0", out_id); else n_pass++;
        d[1] = 8'h3C; a[1] = 3'd4; req_dir[1] = 1'b0;
        d[3] = 8'h12; a[3] = 3'd7; req_dir[3] = 1'b1;
        req_valid = 4'b1010;
        #1;
        n_chk++; if (req_ready !== 4'b0000) $display("FAIL arst_ready got=%b exp=0000", req_ready); else n_pass++;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) $display("FAIL arst_no_result got=%0b exp=0", out_valid); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_chk++; if (req_ready !== 4'b0010) $display("FAIL arst_first_grant got=%b exp=0010", req_ready); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b1000;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) @(negedge clk);
            n_chk++; if (out_valid !== 1'b0 || req_ready !== 4'b0000)
                $display("FAIL arst_busy cycle=%0d got=%0b/%b exp=0/0000", c, out_valid, req_ready); else n_pass++;
        end
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1) $display("FAIL arst_r1_valid got=%0b exp=1", out_valid); else n_pass++;
        n_chk++; if (out_id !== 2'd1) $display("FAIL arst_r1_id got=%0d exp=1", out_id); else n_pass++;
        n_chk++; if (out_data !== 8'hC3) $display("FAIL arst_r1_data got=%h exp=c3", out_data); else n_pass++;
        @(negedge clk);
        n_chk++; if (req_ready !== 4'b1000) $display("FAIL arst_second_grant got=%b exp=1000", req_ready); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'h0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1) $display("FAIL arst_r3_valid got=%0b exp=1", out_valid); else n_pass++;
        n_chk++; if (out_id !== 2'd3) $display("FAIL arst_r3_id got=%0d exp=3", out_id); else n_pass++;
        n_chk++; if (out_data !== 8'h09) $display("FAIL arst_r3_data got=%h exp=09", out_data); else n_pass++;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) $display("FAIL arst_r3_released got=%0b exp=0", out_valid); else n_pass++;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        req_dir = 4'h0;
        for (int i = 0; i < 4; i++) begin
            d[i] = 8'h00;
            a[i] = 3'd0;
        end
        test_reset();
        test_single_op(2'd0, 8'hB1, 3'd3, 1'b0, 8'h36, "ror3");
        test_single_op(2'd2, 8'hB1, 3'd1, 1'b1, 8'h63, "rol1");
        test_single_op(2'd1, 8'h5A, 3'd0, 1'b0, 8'h5A, "amt0");
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
